// File: rtl/host_pkg.sv
// Shared definitions for the host bus sequencer: FSM encoding, default bus
// timing and a0 meanings.
package host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RECOV  = 3'd4
    } state_t;

    localparam logic [3:0] T_SETUP_DEF  = 4'd1;
    localparam logic [3:0] T_STROBE_DEF = 4'd5;
    localparam logic [3:0] T_HOLD_DEF   = 4'd1;
    localparam logic [3:0] T_RECOV_DEF  = 4'd5;

    localparam logic A0_CMD = 1'b1;
    localparam logic A0_DAT = 1'b0;

    // A phase length of 0 would never expire, so it is treated as 1.
    function automatic logic [3:0] phase_len(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/host_tmr.sv
// Loadable 4-bit down-counter timing one bus phase; tc flags the last cycle
// of the phase that was loaded.
module host_tmr
    import host_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       tc
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= phase_len(load_val);
        end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign tc = (cnt == 4'd1);

endmodule

// File: rtl/host_bus_seq.sv
// Sequences one parallel-bus access (setup, strobe, hold, recovery) per
// accepted request, with all bus pins driven from registers.
module host_bus_seq
    import host_pkg::*;
#(
    parameter logic [3:0] T_SETUP  = T_SETUP_DEF,
    parameter logic [3:0] T_STROBE = T_STROBE_DEF,
    parameter logic [3:0] T_HOLD   = T_HOLD_DEF,
    parameter logic [3:0] T_RECOV  = T_RECOV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic       req_a0,
    input  logic       req_rd,
    input  logic [7:0] req_dat,
    output logic       rsp_vld,
    output logic [7:0] rsp_dat,
    output logic       busy,
    output logic       cs_x,
    output logic       rd_x,
    output logic       wr_x,
    output logic       a0,
    output logic [7:0] dat_o,
    output logic       dat_oe,
    input  logic [7:0] dat_i
);

    state_t     state;
    logic       lat_rd;
    logic [7:0] lat_dat;
    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_tc;

    // Handshake: a request transfers on a rising edge where req_vld and
    // req_rdy are both 1; req_rdy is only offered in IDLE outside reset.
    assign req_rdy = (state == ST_IDLE) && !rst;
    assign busy    = (state != ST_IDLE);

    // The timer is reloaded with the length of the phase about to start.
    always_comb begin
        tmr_val  = T_SETUP;
        tmr_load = (state == ST_IDLE) || tmr_tc;
        case (state)
            ST_SETUP:  tmr_val = T_STROBE;
            ST_STROBE: tmr_val = T_HOLD;
            ST_HOLD:   tmr_val = T_RECOV;
            default:   tmr_val = T_SETUP;
        endcase
    end

    host_tmr u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lat_rd  <= 1'b0;
            lat_dat <= 8'h00;
            cs_x    <= 1'b1;
            rd_x    <= 1'b1;
            wr_x    <= 1'b1;
            a0      <= A0_DAT;
            dat_o   <= 8'h00;
            dat_oe  <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_dat <= 8'h00;
        end else begin
            rsp_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        lat_rd  <= req_rd;
                        lat_dat <= req_dat;
                        a0      <= req_a0;
                        cs_x    <= 1'b0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_tc) begin
                        wr_x   <= lat_rd;
                        rd_x   <= !lat_rd;
                        dat_oe <= !lat_rd;
                        dat_o  <= lat_rd ? 8'h00 : lat_dat;
                        state  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tmr_tc) begin
                        wr_x  <= 1'b1;
                        rd_x  <= 1'b1;
                        if (lat_rd) begin
                            rsp_dat <= dat_i;
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
                        cs_x    <= 1'b1;
                        dat_oe  <= 1'b0;
                        dat_o   <= 8'h00;
                        rsp_vld <= lat_rd;
                        state   <= ST_RECOV;
                    end
                end
                ST_RECOV: begin
                    if (tmr_tc) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_bus_seq.sv
// Bench for host_bus_seq: default-timing instance checked by a bus monitor
// and scoreboard, plus a second instance with T_SETUP=0 / T_STROBE=15.
module tb_host_bus_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic       req_vld = 1'b0;
    logic       req_a0  = 1'b0;
    logic       req_rd  = 1'b0;
    logic [7:0] req_dat = 8'h00;
    logic       req_rdy, rsp_vld, busy, cs_x, rd_x, wr_x, a0, dat_oe;
    logic [7:0] rsp_dat, dat_o, dat_i;
    logic [7:0] dev_dat = 8'h00;

    // Simple bus device: drives its data only while rd_x is low.
    assign dat_i = rd_x ? 8'hFF : dev_dat;

    host_bus_seq dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a0(req_a0), .req_rd(req_rd), .req_dat(req_dat),
        .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .busy(busy),
        .cs_x(cs_x), .rd_x(rd_x), .wr_x(wr_x), .a0(a0),
        .dat_o(dat_o), .dat_oe(dat_oe), .dat_i(dat_i)
    );

    logic       b_vld = 1'b0;
    logic       b_rdy, b_rsp_vld, b_busy, b_cs_x, b_rd_x, b_wr_x, b_a0, b_dat_oe;
    logic [7:0] b_rsp_dat, b_dat_o;

    host_bus_seq #(.T_SETUP(4'd0), .T_STROBE(4'd15), .T_HOLD(4'd1), .T_RECOV(4'd5)) dut2 (
        .clk(clk), .rst(rst), .req_vld(b_vld), .req_rdy(b_rdy),
        .req_a0(req_a0), .req_rd(req_rd), .req_dat(req_dat),
        .rsp_vld(b_rsp_vld), .rsp_dat(b_rsp_dat), .busy(b_busy),
        .cs_x(b_cs_x), .rd_x(b_rd_x), .wr_x(b_wr_x), .a0(b_a0),
        .dat_o(b_dat_o), .dat_oe(b_dat_oe), .dat_i(dat_i)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- bus monitor (default instance) ----------------
    int         wr_len = 0, rd_len = 0, rsp_cnt = 0, proto_err = 0;
    int         cs_hi = 0, last_gap = -1;
    logic       seen_cs = 1'b0, wr_stable = 1'b0;
    logic [8:0] wr_cap = 9'h0, e9 = 9'h0;
    logic [7:0] e8 = 8'h0;

    always @(negedge clk) begin
        if (rst) begin
            wr_len = 0; rd_len = 0; cs_hi = 0; seen_cs = 1'b0;
        end else begin
            if ((!wr_x && !rd_x) || ((!wr_x || !rd_x) && cs_x)) proto_err++;
            if (!wr_x) begin
                if (wr_len == 0) begin
                    wr_cap = {a0, dat_o};
                    wr_stable = dat_oe;
                end else if ({a0, dat_o} != wr_cap || !dat_oe) begin
                    wr_stable = 1'b0;
                end
                wr_len++;
            end else if (wr_len != 0) begin
                check("wr_q_avail", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    e9 = exp_wr_q.pop_front();
                    check("wr_a0_data", 32'(wr_cap), 32'(e9));
                end
                check("wr_strobe_len", wr_len, 5);
                check("wr_data_stable", 32'(wr_stable), 32'd1);
                wr_len = 0;
            end
            if (!rd_x) begin
                rd_len++;
            end else if (rd_len != 0) begin
                check("rd_strobe_len", rd_len, 5);
                rd_len = 0;
            end
            if (rsp_vld) begin
                rsp_cnt++;
                check("rd_q_avail", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) begin
                    e8 = exp_rd_q.pop_front();
                    check("rsp_dat", 32'(rsp_dat), 32'(e8));
                end
            end
            if (cs_x) begin
                cs_hi++;
            end else begin
                if (cs_hi != 0 && seen_cs) last_gap = cs_hi;
                cs_hi = 0;
                seen_cs = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a negedge; returns on the negedge after the transfer edge.
    // t is the cycle count of the transfer cycle.
    task automatic send(input logic a0v, input logic rdv, input logic [7:0] d,
                        input logic push, input logic hold, output int t);
        int n = 0;
        req_vld = 1'b1; req_a0 = a0v; req_rd = rdv; req_dat = d;
        while (!req_rdy && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("xfer_timeout", 32'(req_rdy), 32'd1);
        t = cyc;
        if (push) begin
            if (rdv) exp_rd_q.push_back(dev_dat);
            else     exp_wr_q.push_back({a0v, d});
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_vld = 1'b0;
    endtask

    task automatic measure(input int n, input logic [7:0] xd, input int t0,
                           output int cs_lo, output int wr_lo, output int rd_lo,
                           output int oe_ok, output int oe_hi, output int rsp_n,
                           output int rdy_gap);
        cs_lo = 0; wr_lo = 0; rd_lo = 0; oe_ok = 0; oe_hi = 0; rsp_n = 0; rdy_gap = -1;
        for (int i = 0; i < n; i++) begin
            if (!cs_x) cs_lo++;
            if (!wr_x) wr_lo++;
            if (!rd_x) rd_lo++;
            if (dat_oe) oe_hi++;
            if (dat_oe && dat_o == xd) oe_ok++;
            if (rsp_vld) rsp_n++;
            if (req_rdy && rdy_gap < 0) rdy_gap = cyc - t0;
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    int t1, t2, cs_lo, wr_lo, rd_lo, oe_ok, oe_hi, rsp_n, rdy_gap, n, rsp_before;
    int b_setup, b_wr, b_ok, b_gap;
    logic b_strobe_seen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_x", 32'(cs_x), 32'd1);
        check("rst_strobes", 32'({rd_x, wr_x}), 32'h3);
        check("rst_a0", 32'(a0), 32'd0);
        check("rst_dat", 32'({dat_oe, dat_o}), 32'h000);
        check("rst_rsp", 32'({rsp_vld, rsp_dat}), 32'h000);
        check("rst_busy_rdy", 32'({busy, req_rdy}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 32'(req_rdy), 32'd1);

        // command write
        send(1'b1, 1'b0, 8'h40, 1'b1, 1'b0, t1);
        measure(20, 8'h40, t1, cs_lo, wr_lo, rd_lo, oe_ok, oe_hi, rsp_n, rdy_gap);
        check("cmd_cs_low", cs_lo, 7);
        check("cmd_wr_low", wr_lo, 5);
        check("cmd_oe_data", oe_ok, 6);
        check("cmd_a0", 32'(a0), 32'd1);
        check("cmd_rdy_gap", rdy_gap, 13);

        // back-to-back data writes with req_vld held
        send(1'b0, 1'b0, 8'h38, 1'b1, 1'b1, t1);
        send(1'b0, 1'b0, 8'h07, 1'b1, 1'b0, t2);
        check("b2b_spacing", t2 - t1, 13);
        measure(20, 8'h07, t2, cs_lo, wr_lo, rd_lo, oe_ok, oe_hi, rsp_n, rdy_gap);
        check("b2b_cs_gap_ge5", 32'(last_gap >= 5), 32'd1);
        check("b2b_a0", 32'(a0), 32'd0);

        // read
        dev_dat = 8'hA5;
        send(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, t1);
        measure(20, 8'h00, t1, cs_lo, wr_lo, rd_lo, oe_ok, oe_hi, rsp_n, rdy_gap);
        check("rd_rd_low", rd_lo, 5);
        check("rd_wr_low", wr_lo, 0);
        check("rd_oe", oe_hi, 0);
        check("rd_rsp_pulses", rsp_n, 1);
        check("rd_rdy_gap", rdy_gap, 13);

        // request inputs change while busy
        send(1'b0, 1'b0, 8'h55, 1'b1, 1'b0, t1);
        req_dat = 8'hAA; req_a0 = 1'b1; req_rd = 1'b1;
        measure(20, 8'h55, t1, cs_lo, wr_lo, rd_lo, oe_ok, oe_hi, rsp_n, rdy_gap);
        check("busy_chg_oe_data", oe_ok, 6);
        check("busy_chg_rd_low", rd_lo, 0);
        check("rsp_dat_held", 32'(rsp_dat), 32'hA5);

        // reset in the third strobe cycle of a write
        send(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, t1);
        n = 0;
        while (wr_x && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_strobe_seen", 32'(wr_x), 32'd0);
        repeat (2) @(negedge clk);
        rsp_before = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_wr_x", 32'(wr_x), 32'd1);
        check("abort_cs_x", 32'(cs_x), 32'd1);
        check("abort_oe", 32'(dat_oe), 32'd0);
        check("abort_busy_rdy", 32'({busy, req_rdy}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rdy_back", 32'(req_rdy), 32'd1);
        repeat (8) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - rsp_before, 0);
        send(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, t1);
        measure(20, 8'h3C, t1, cs_lo, wr_lo, rd_lo, oe_ok, oe_hi, rsp_n, rdy_gap);
        check("post_abort_oe_data", oe_ok, 6);
        check("post_abort_rdy_gap", rdy_gap, 13);

        // second instance: T_SETUP=0 behaves as 1, T_STROBE=15
        req_a0 = 1'b0; req_rd = 1'b0; req_dat = 8'h99; b_vld = 1'b1;
        n = 0;
        while (!b_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        @(posedge clk);
        @(negedge clk);
        b_vld = 1'b0;
        b_setup = 0; b_wr = 0; b_ok = 0; b_gap = -1; b_strobe_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!b_wr_x) b_strobe_seen = 1'b1;
            if (!b_cs_x && b_wr_x && !b_strobe_seen) b_setup++;
            if (!b_wr_x) b_wr++;
            if (b_dat_oe && b_dat_o == 8'h99) b_ok++;
            if (b_rdy && b_gap < 0) b_gap = cyc - t1;
            @(negedge clk);
        end
        check("t0_setup_len", b_setup, 1);
        check("t15_wr_low", b_wr, 15);
        check("t15_oe_data", b_ok, 16);
        check("t15_rdy_gap", b_gap, 23);

        // final
        repeat (4) @(negedge clk);
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
        check("bus_protocol", proto_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
